// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter path.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 4.
  localparam int unsigned LAT_CNT_W = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_MemR;
  logic              mem_MemW;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Requesters plus the memory itself.
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1,
    input  mem_MemR, mem_MemW, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, done0, rdata0, gnt1, done1, rdata1,
    output mem_MemR, mem_MemW, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; the port that did not win last time wins a tie.
module rr_pick2
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = (req0 && req1) ? ~last : (req1 ? PORT1 : PORT0);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto the single-port data memory; one transaction in flight,
// all outputs registered.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  state_e                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   win_q, win_d;
  logic                   we_q, we_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]      maddr_q, maddr_d;
  logic [DATA_W-1:0]      mwdata_q, mwdata_d;
  logic [DATA_W-1:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                   gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                   done0_q, done0_d, done1_q, done1_d;
  logic                   memr_q, memr_d, memw_q, memw_d;
  logic                   busy_q, busy_d;

  logic                   pick_valid, pick_win;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  rr_pick2 u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_win)
  );

  always_comb begin
    sel_we    = (pick_win == PORT1) ? bus.we1    : bus.we0;
    sel_addr  = (pick_win == PORT1) ? bus.addr1  : bus.addr0;
    sel_wdata = (pick_win == PORT1) ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    memr_d   = 1'b0;
    memw_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = ISSUE;
          win_d    = pick_win;
          last_d   = pick_win;
          we_d     = sel_we;
          maddr_d  = sel_addr;
          mwdata_d = sel_wdata;
          gnt0_d   = (pick_win == PORT0);
          gnt1_d   = (pick_win == PORT1);
          memr_d   = ~sel_we;
          memw_d   = sel_we;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
          done0_d = (win_q == PORT0);
          done1_d = (win_q == PORT1);
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_CNT_W'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          done0_d = (win_q == PORT0);
          done1_d = (win_q == PORT1);
          if (win_q == PORT0) rdata0_d = bus.mem_rdata;
          else                rdata1_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= PORT1;
      win_q    <= PORT0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      memr_q   <= 1'b0;
      memw_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      memr_q   <= memr_d;
      memw_q   <= memw_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_MemR  = memr_q;
  assign bus.mem_MemW  = memw_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: cycle table for a MEM_LAT=1 arbiter plus sequences for latency and reset.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } port_t;

  typedef struct {
    logic        rst;
    port_t       p0;
    port_t       p1;
    logic [6:0]  ctl;  // {gnt0, gnt1, done0, done1, MemR, MemW, busy}
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  localparam port_t NOP   = '{1'b0, 1'b0, 32'h0, 32'h0};
  localparam port_t RD0_5 = '{1'b1, 1'b0, 32'h5, 32'h0};
  localparam port_t RD0_7 = '{1'b1, 1'b0, 32'h7, 32'h0};
  localparam port_t WR1_7 = '{1'b1, 1'b1, 32'h7, 32'hDEAD_BEEF};
  localparam port_t WR0_C = '{1'b1, 1'b1, 32'h10, 32'h11};
  localparam port_t WR1_C = '{1'b1, 1'b1, 32'hA000_0020, 32'h22};
  localparam port_t WR1_9 = '{1'b1, 1'b1, 32'h9, 32'h99};

  localparam logic [6:0] C_IDLE = 7'b000_0000;
  localparam logic [6:0] C_BUSY = 7'b000_0001;
  localparam logic [6:0] C_G0R  = 7'b100_0101;
  localparam logic [6:0] C_G0W  = 7'b100_0011;
  localparam logic [6:0] C_G1W  = 7'b010_0011;
  localparam logic [6:0] C_D0   = 7'b001_0001;
  localparam logic [6:0] C_D1   = 7'b000_1001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t tbl[$];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  // Memory models: read data is valid only exactly MEM_LAT cycles after the strobe.
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] mrd1, p3a, p3b, p3c;

  always @(posedge clk) begin
    if (b1.mem_MemW) mem1[b1.mem_addr[9:0]] <= b1.mem_wdata;
    mrd1 <= b1.mem_MemR ? mem1[b1.mem_addr[9:0]] : 32'hBAD0_0001;
    if (b3.mem_MemW) mem3[b3.mem_addr[9:0]] <= b3.mem_wdata;
    p3a <= b3.mem_MemR ? mem3[b3.mem_addr[9:0]] : 32'hBAD0_0003;
    p3b <= p3a;
    p3c <= p3b;
  end

  assign b1.mem_rdata = mrd1;
  assign b3.mem_rdata = p3c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl1();
    return {b1.gnt0, b1.gnt1, b1.done0, b1.done1, b1.mem_MemR, b1.mem_MemW, b1.busy};
  endfunction

  function automatic logic [6:0] ctl3();
    return {b3.gnt0, b3.gnt1, b3.done0, b3.done1, b3.mem_MemR, b3.mem_MemW, b3.busy};
  endfunction

  task automatic add(input logic r, input port_t a, input port_t b, input logic [6:0] c,
                     input logic [31:0] ma, input logic [31:0] mw,
                     input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.rst = r; v.p0 = a; v.p1 = b; v.ctl = c;
    v.maddr = ma; v.mwdata = mw; v.rd0 = r0; v.rd1 = r1;
    tbl.push_back(v);
  endtask

  task automatic drive1(input port_t a, input port_t b);
    b1.req0 = a.req; b1.we0 = a.we; b1.addr0 = a.addr; b1.wdata0 = a.wdata;
    b1.req1 = b.req; b1.we1 = b.we; b1.addr1 = b.addr; b1.wdata1 = b.wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    drive1(NOP, NOP);
    b3.req0 = 1'b0; b3.we0 = 1'b0; b3.addr0 = '0; b3.wdata0 = '0;
    b3.req1 = 1'b0; b3.we1 = 1'b0; b3.addr1 = '0; b3.wdata1 = '0;
    mem1[5] = 32'h0000_002A;
    mem1[7] = 32'h0000_0000;
    mem3[2] = 32'h1234_5678;

    // Row inputs are sampled at the next edge; expectations hold just after that edge.
    add(1'b0, NOP,   NOP,   C_IDLE, 32'h0, 32'h0, 32'h0, 32'h0);          // reset
    add(1'b1, NOP,   NOP,   C_IDLE, 32'h0, 32'h0, 32'h0, 32'h0);
    add(1'b1, RD0_5, NOP,   C_G0R,  32'h5, 32'h0, 32'h0, 32'h0);          // single read
    add(1'b1, NOP,   NOP,   C_BUSY, 32'h5, 32'h0, 32'h0, 32'h0);
    add(1'b1, NOP,   NOP,   C_D0,   32'h5, 32'h0, 32'h2A, 32'h0);
    add(1'b1, NOP,   NOP,   C_IDLE, 32'h5, 32'h0, 32'h2A, 32'h0);
    add(1'b1, NOP,   WR1_7, C_G1W,  32'h7, 32'hDEAD_BEEF, 32'h2A, 32'h0);  // single write
    add(1'b1, NOP,   NOP,   C_D1,   32'h7, 32'hDEAD_BEEF, 32'h2A, 32'h0);
    add(1'b1, NOP,   NOP,   C_IDLE, 32'h7, 32'hDEAD_BEEF, 32'h2A, 32'h0);
    add(1'b1, RD0_7, NOP,   C_G0R,  32'h7, 32'h0, 32'h2A, 32'h0);          // read back
    add(1'b1, NOP,   NOP,   C_BUSY, 32'h7, 32'h0, 32'h2A, 32'h0);
    add(1'b1, NOP,   NOP,   C_D0,   32'h7, 32'h0, 32'hDEAD_BEEF, 32'h0);
    add(1'b1, NOP,   NOP,   C_IDLE, 32'h7, 32'h0, 32'hDEAD_BEEF, 32'h0);
    add(1'b0, WR0_C, WR1_C, C_IDLE, 32'h0, 32'h0, 32'h0, 32'h0);          // contention
    add(1'b1, WR0_C, WR1_C, C_G0W,  32'h10, 32'h11, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_D0,   32'h10, 32'h11, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_IDLE, 32'h10, 32'h11, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_G1W,  32'hA000_0020, 32'h22, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_D1,   32'hA000_0020, 32'h22, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_IDLE, 32'hA000_0020, 32'h22, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_G0W,  32'h10, 32'h11, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_D0,   32'h10, 32'h11, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_IDLE, 32'h10, 32'h11, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_G1W,  32'hA000_0020, 32'h22, 32'h0, 32'h0);
    add(1'b1, WR0_C, WR1_C, C_D1,   32'hA000_0020, 32'h22, 32'h0, 32'h0);
    add(1'b1, NOP,   NOP,   C_IDLE, 32'hA000_0020, 32'h22, 32'h0, 32'h0);
    add(1'b1, RD0_5, NOP,   C_G0R,  32'h5, 32'h0, 32'h0, 32'h0);          // withdrawn req1
    add(1'b1, NOP,   NOP,   C_BUSY, 32'h5, 32'h0, 32'h0, 32'h0);
    add(1'b1, NOP,   NOP,   C_D0,   32'h5, 32'h0, 32'h2A, 32'h0);
    add(1'b1, NOP,   WR1_9, C_IDLE, 32'h5, 32'h0, 32'h2A, 32'h0);          // pulse in RESP
    add(1'b1, NOP,   NOP,   C_IDLE, 32'h5, 32'h0, 32'h2A, 32'h0);
    add(1'b1, NOP,   NOP,   C_IDLE, 32'h5, 32'h0, 32'h2A, 32'h0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      drive1(tbl[i].p0, tbl[i].p1);
      step();
      check($sformatf("row%0d ctl", i), 32'(ctl1()), 32'(tbl[i].ctl));
      check($sformatf("row%0d mem_addr", i), b1.mem_addr, tbl[i].maddr);
      check($sformatf("row%0d mem_wdata", i), b1.mem_wdata, tbl[i].mwdata);
      check($sformatf("row%0d rdata0", i), b1.rdata0, tbl[i].rd0);
      check($sformatf("row%0d rdata1", i), b1.rdata1, tbl[i].rd1);
    end

    // MEM_LAT=3 read of addr 2: grant in cycle 1, WAIT cycles 2-4, done in cycle 5.
    b3.req0 = 1'b1; b3.we0 = 1'b0; b3.addr0 = 32'h2;
    step();
    check("lat3 c1 ctl", 32'(ctl3()), 32'(C_G0R));
    check("lat3 c1 mem_addr", b3.mem_addr, 32'h2);
    b3.req0 = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      step();
      check($sformatf("lat3 c%0d ctl", c), 32'(ctl3()), 32'(C_BUSY));
    end
    step();
    check("lat3 c5 ctl", 32'(ctl3()), 32'(C_D0));
    check("lat3 c5 rdata0", b3.rdata0, 32'h1234_5678);
    step();
    check("lat3 c6 ctl", 32'(ctl3()), 32'(C_IDLE));

    // Reset while waiting on read data; port 0 won last, so reset must restore its priority.
    drive1(RD0_5, NOP);
    step();
    check("rst-mid grant", 32'(ctl1()), 32'(C_G0R));
    drive1(NOP, NOP);
    step();
    check("rst-mid wait", 32'(ctl1()), 32'(C_BUSY));
    rst = 1'b0;
    step();
    check("rst-mid ctl", 32'(ctl1()), 32'(C_IDLE));
    check("rst-mid mem_addr", b1.mem_addr, 32'h0);
    check("rst-mid rdata0", b1.rdata0, 32'h0);
    rst = 1'b1;
    step();
    check("rst-mid no done", 32'(ctl1()), 32'(C_IDLE));
    drive1(WR0_C, WR1_C);
    step();
    check("rst-mid first contention", 32'(ctl1()), 32'(C_G0W));
    drive1(NOP, NOP);
    repeat (3) step();
    check("rst-mid settle", 32'(ctl1()), 32'(C_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
